// File: rtl/three_parallel_serializer_if.sv
// Block-in / sample-out stream bundle for the three-lane serializer.
// The block side carries three lane samples; the sample side is a valid/ready stream.
interface three_parallel_serializer_if #(
  parameter int ACC_W = 64,
  parameter int OUT_W = 16
);
  logic                    blk_valid;
  logic                    blk_ready;
  logic signed [ACC_W-1:0] blk_y0;
  logic signed [ACC_W-1:0] blk_y1;
  logic signed [ACC_W-1:0] blk_y2;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (
    output blk_valid, blk_y0, blk_y1, blk_y2, out_ready,
    input  blk_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  blk_valid, blk_y0, blk_y1, blk_y2, out_ready,
    output blk_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/three_parallel_serializer.sv
// Two-deep block buffer feeding a three-lane serializer with round-half-up and
// saturation from Q-scaled accumulator lanes to OUT_W-bit samples.
module three_parallel_serializer #(
  parameter int ACC_W = 64,
  parameter int FRAC  = 31,
  parameter int OUT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  three_parallel_serializer_if.slave  bus,
  output logic [15:0]                 sat_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] mem [2][3];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic [1:0]              lane;
  state_t                  state;
  logic signed [OUT_W-1:0] data_q;
  logic                    last_q;
  logic                    sat_q;

  logic                    push;
  logic                    xfer;
  logic                    pop;
  logic [1:0]              lane_nxt;
  logic signed [ACC_W-1:0] src;
  logic signed [ACC_W:0]   rsum;
  logic signed [ACC_W:0]   rshift;
  logic signed [OUT_W-1:0] data_nxt;
  logic                    sat_nxt;

  assign bus.blk_ready = (count != 2'd2);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

  assign push     = bus.blk_valid && bus.blk_ready;
  assign xfer     = bus.out_valid && bus.out_ready;
  assign pop      = xfer && (lane == 2'd2);
  assign lane_nxt = lane + 2'd1;

  // Pick the sample to register next; on a lane-2 pop with a single buffered
  // block the incoming block is forwarded so the stream has no bubble.
  always_comb begin
    src = mem[rd_ptr][0];
    if (xfer && !pop) begin
      src = mem[rd_ptr][lane_nxt];
    end else if (pop) begin
      src = (count == 2'd1) ? bus.blk_y0 : mem[~rd_ptr][0];
    end

    rsum    = {src[ACC_W-1], src} + HALF;
    rshift  = rsum >>> FRAC;
    sat_nxt = (rshift > SAT_MAX) || (rshift < SAT_MIN);
    if (rshift > SAT_MAX) begin
      data_nxt = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (rshift < SAT_MIN) begin
      data_nxt = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      data_nxt = rshift[OUT_W-1:0];
    end
  end

  // NOTE: the block storage is deliberately not reset; count and the pointers
  // alone define which entries are live, so clearing them empties the buffer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr][0] <= bus.blk_y0;
      mem[wr_ptr][1] <= bus.blk_y1;
      mem[wr_ptr][2] <= bus.blk_y2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      lane      <= 2'd0;
      data_q    <= '0;
      last_q    <= 1'b0;
      sat_q     <= 1'b0;
      sat_count <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (xfer && sat_q && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            state  <= EMIT;
            lane   <= 2'd0;
            data_q <= data_nxt;
            sat_q  <= sat_nxt;
            last_q <= 1'b0;
          end
        end
        EMIT: begin
          if (xfer && !pop) begin
            lane   <= lane_nxt;
            data_q <= data_nxt;
            sat_q  <= sat_nxt;
            last_q <= (lane_nxt == 2'd2);
          end else if (pop) begin
            lane   <= 2'd0;
            last_q <= 1'b0;
            if ((count == 2'd2) || push) begin
              data_q <= data_nxt;
              sat_q  <= sat_nxt;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_three_parallel_serializer.sv
// Scoreboard bench for three_parallel_serializer: directed scenarios plus a
// randomized run checked against an arithmetic round/saturate model.
module tb_three_parallel_serializer;

  localparam int ACC_W = 64;
  localparam int FRAC  = 31;
  localparam int OUT_W = 16;

  typedef struct {
    logic signed [OUT_W-1:0] d;
    logic                    last;
    logic                    sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sat_count;

  three_parallel_serializer_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  three_parallel_serializer #(.ACC_W(ACC_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   last_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_sat = 0;
  int   n_acc = 0;
  bit   rand_ready = 1'b0;
  int   acc_a, acc_b, acc_c, acc_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // Reference: floor(y / 2^FRAC + 1/2), then clamp to the OUT_W signed range.
  function automatic exp_t model(input longint y, input logic last);
    longint q;
    longint r;
    exp_t   e;
    q = y >>> FRAC;
    r = y & ((64'sd1 <<< FRAC) - 1);
    if (r >= (64'sd1 <<< (FRAC - 1))) q = q + 1;
    e.last = last;
    e.sat  = (q > 32767) || (q < -32768);
    if (q > 32767)       e.d = 16'sh7FFF;
    else if (q < -32768) e.d = 16'sh8000;
    else                 e.d = q[15:0];
    return e;
  endfunction

  function automatic longint rand_y();
    longint k;
    longint f;
    f = longint'($urandom) & 64'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0: begin
        k = longint'($urandom_range(0, 80000)) - 40000;
        return (k <<< 31) + f;
      end
      1: begin
        k = longint'($urandom_range(0, 200)) - 100;
        return (k <<< 31) + (64'sd1 <<< 30);
      end
      2: return {$urandom, $urandom};
      default: begin
        k = longint'($urandom_range(32766, 32768));
        if ($urandom_range(0, 1) == 1) k = -k;
        return (k <<< 31) + f;
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard on every transfer and checks stability under stall.
  logic                    hold_pending = 1'b0;
  logic signed [OUT_W-1:0] hold_d;
  logic                    hold_l;
  exp_t                    mon_e;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, hold_d);
        check("hold_last", bus.out_last, hold_l);
      end
      hold_pending = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        hold_pending = 1'b1;
        hold_d = bus.out_data;
        hold_l = bus.out_last;
      end else if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("data", bus.out_data, mon_e.d);
          check("last", bus.out_last, mon_e.last);
          if (mon_e.sat && exp_sat < 65535) exp_sat++;
          xfer_cyc.push_back(cyc);
          if (mon_e.last) last_cyc.push_back(cyc);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_block(input longint y0, input longint y1, input longint y2,
                            output int acc);
    bit ok;
    bus.blk_valid = 1'b1;
    bus.blk_y0 = y0;
    bus.blk_y1 = y1;
    bus.blk_y2 = y2;
    acc = -1;
    for (int b = 0; b < 300; b++) begin
      @(negedge clk);
      ok = bus.blk_ready && !rst;
      @(posedge clk);
      #1;
      if (ok) begin
        acc = cyc;
        break;
      end
    end
    bus.blk_valid = 1'b0;
    if (acc < 0) begin
      check("accept_timeout", 0, 1);
    end else begin
      n_acc++;
      exp_q.push_back(model(y0, 1'b0));
      exp_q.push_back(model(y1, 1'b0));
      exp_q.push_back(model(y2, 1'b1));
    end
  endtask

  task automatic drain(input string name);
    for (int b = 0; b < 500 && exp_q.size() != 0; b++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint r0, r1;
    int     b;
    bus.blk_valid = 1'b0;
    bus.blk_y0 = '0;
    bus.blk_y1 = '0;
    bus.blk_y2 = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_blk_ready", bus.blk_ready, 1);
    check("rst_sat_count", sat_count, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);

    // One block: 3, -5, 7.5 -> 3, -5, 8 on consecutive cycles.
    xfer_cyc.delete();
    send_block(64'sd3 <<< 31, -(64'sd5 <<< 31), (64'sd7 <<< 31) + (64'sd1 <<< 30), acc_a);
    drain("one");
    check("one_count", xfer_cyc.size(), 3);
    check("one_latency", xfer_cyc[0] - acc_a, 1);
    check("one_consecutive", xfer_cyc[2] - xfer_cyc[0], 2);

    // Rounding of -5.5 and saturation both ways.
    send_block(-(64'sd5 <<< 31) - (64'sd1 <<< 30), 64'sd40000 <<< 31,
               -(64'sd40000 <<< 31), acc_a);
    drain("sat");
    check("sat_count_two", sat_count, 2);

    // Backpressure: three blocks offered while the sink stalls.
    bus.out_ready = 1'b0;
    n_acc = 0;
    last_cyc.delete();
    fork
      begin
        send_block(64'sd11 <<< 31, 64'sd12 <<< 31, 64'sd13 <<< 31, acc_a);
        send_block(64'sd21 <<< 31, 64'sd22 <<< 31, 64'sd23 <<< 31, acc_b);
        send_block(64'sd31 <<< 31, 64'sd32 <<< 31, 64'sd33 <<< 31, acc_c);
      end
    join_none
    b = 0;
    while (!bus.out_valid && b < 50) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("bp_first_valid", bus.out_valid, 1);
    repeat (6) @(posedge clk);
    #1;
    check("bp_blk_ready_low", bus.blk_ready, 0);
    check("bp_two_accepts", n_acc, 2);
    bus.out_ready = 1'b1;
    wait fork;
    drain("bp");
    check("bp_third_after_pop", (acc_c >= last_cyc[0] + 2) ? 1 : 0, 1);

    // Streaming: four blocks back-to-back, twelve samples without a gap.
    xfer_cyc.delete();
    send_block(rand_y(), rand_y(), rand_y(), acc_a);
    send_block(rand_y(), rand_y(), rand_y(), acc_b);
    send_block(rand_y(), rand_y(), rand_y(), acc_c);
    send_block(rand_y(), rand_y(), rand_y(), acc_d);
    drain("stream");
    check("stream_count", xfer_cyc.size(), 12);
    check("stream_span", xfer_cyc[11] - xfer_cyc[0], 11);

    // Reset while lane 1 is on the output, with blk_valid held during reset.
    r0 = 64'sd100 <<< 31;
    r1 = 64'sd101 <<< 31;
    send_block(r0, r1, 64'sd102 <<< 31, acc_a);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rstmid_lane1", bus.out_data, model(r1, 1'b0).d);
    rst = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_y0 = 64'sd55 <<< 31;
    exp_q.delete();
    exp_sat = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.blk_valid = 1'b0;
    check("rstmid_out_valid", bus.out_valid, 0);
    check("rstmid_blk_ready", bus.blk_ready, 1);
    check("rstmid_out_data", bus.out_data, 0);
    check("rstmid_sat_count", sat_count, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_ignored_push", bus.out_valid, 0);
    send_block(-(64'sd7 <<< 31), 64'sd8 <<< 31, -(64'sd9 <<< 31), acc_a);
    drain("rstmid");

    // Randomized traffic with random sink stalls and gaps between blocks.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_block(rand_y(), rand_y(), rand_y(), acc_a);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand");
    check("rand_sat_count", sat_count, exp_sat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
